// File: rtl/shift_pkg.sv
//------------------------------------------------------------------------------
// Module      : shift_pkg
// Description : Shared operation and FSM-state encodings for the shift sequencer.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package shift_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_LOAD = 3'd1,
        OP_SHR  = 3'd2,
        OP_SHL  = 3'd3,
        OP_ROR  = 3'd4,
        OP_ROL  = 3'd5,
        OP_ASR  = 3'd6,
        OP_LSL  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
//------------------------------------------------------------------------------
// Module      : shift_step
// Description : Combinational single-bit step: next data value and the bit
//               that falls out of the register for the selected operation.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_q,
    input  op_e              i_op,
    input  logic             i_msb_in,
    input  logic             i_lsb_in,
    output logic [WIDTH-1:0] o_q_next,
    output logic             o_out_bit
);

    always_comb begin
        o_q_next  = i_q;
        o_out_bit = 1'b0;
        case (i_op)
            OP_SHR: begin
                o_q_next  = {i_msb_in, i_q[WIDTH-1:1]};
                o_out_bit = i_q[0];
            end
            OP_SHL: begin
                o_q_next  = {i_q[WIDTH-2:0], i_lsb_in};
                o_out_bit = i_q[WIDTH-1];
            end
            OP_ROR: begin
                o_q_next  = {i_q[0], i_q[WIDTH-1:1]};
                o_out_bit = i_q[0];
            end
            OP_ROL: begin
                o_q_next  = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
                o_out_bit = i_q[WIDTH-1];
            end
            OP_ASR: begin
                o_q_next  = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
                o_out_bit = i_q[0];
            end
            OP_LSL: begin
                o_q_next  = {i_q[WIDTH-2:0], 1'b0};
                o_out_bit = i_q[WIDTH-1];
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/shift_sequencer.sv
//------------------------------------------------------------------------------
// Module      : shift_sequencer
// Description : Multi-cycle shift/rotate sequencer: accepts an op in IDLE, runs
//               one step per enabled cycle in RUN, pulses done for one cycle.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   d,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               msb_in,
    input  logic               lsb_in,
    output logic [WIDTH-1:0]   q,
    output logic               ser_out,
    output logic               busy,
    output logic               done
);

    state_e               r_state;
    op_e                  r_op;
    logic [SHAMT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_q;
    logic                 r_ser;
    logic                 r_busy;
    logic                 r_done;

    logic [WIDTH-1:0]     w_q_next;
    logic                 w_out_bit;
    op_e                  w_op_in;

    assign w_op_in = op_e'(op);

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_q       (r_q),
        .i_op      (r_op),
        .i_msb_in  (msb_in),
        .i_lsb_in  (lsb_in),
        .o_q_next  (w_q_next),
        .o_out_bit (w_out_bit)
    );

    // rst is active low; busy/done are registered alongside the state so they
    // track it exactly without decoding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_HOLD;
            r_cnt   <= '0;
            r_q     <= '0;
            r_ser   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en && start) begin
                        r_op <= w_op_in;
                        if (w_op_in == OP_LOAD) begin
                            r_q <= d;
                        end
                        if (w_op_in == OP_HOLD || w_op_in == OP_LOAD || shamt == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt   <= shamt;
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (en) begin
                        r_q   <= w_q_next;
                        r_ser <= w_out_bit;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == SHAMT_W'(1)) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // Leaves DONE unconditionally so done never stretches.
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign q       = r_q;
    assign ser_out = r_ser;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_shift_sequencer
// Description : Self-checking bench: vector table plus directed multi-cycle cases.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_shift_sequencer;

    localparam int WIDTH   = 8;
    localparam int SHAMT_W = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en = 1'b1;
    logic               start = 1'b0;
    logic [2:0]         op = 3'd0;
    logic [WIDTH-1:0]   d = '0;
    logic [SHAMT_W-1:0] shamt = '0;
    logic               msb_in = 1'b0;
    logic               lsb_in = 1'b0;
    logic [WIDTH-1:0]   q;
    logic               ser_out;
    logic               busy;
    logic               done;

    int n_cmp = 0;
    int n_err = 0;

    shift_sequencer #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .start   (start),
        .op      (op),
        .d       (d),
        .shamt   (shamt),
        .msb_in  (msb_in),
        .lsb_in  (lsb_in),
        .q       (q),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] preset;
        logic [2:0] op;
        logic [3:0] k;
        logic [7:0] ld;
        logic       msb;
        logic       lsb;
        logic [7:0] exp_q;
        logic       chk_ser;
        logic       exp_ser;
        int         exp_busy;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one op from IDLE; returns busy-cycle count and edges until done.
    task automatic do_op(input logic [2:0] op_i, input logic [3:0] k, input logic [7:0] d_i,
                         output int nbusy, output int lat);
        @(negedge clk);
        start = 1'b1;
        op    = op_i;
        shamt = k;
        d     = d_i;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        nbusy = 0;
        while (!done && lat < 200) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        if (!done) check("done_timeout", 64'(lat), 64'd0);
    endtask

    task automatic load(input logic [7:0] v);
        int nb, lt;
        do_op(3'd1, 4'd0, v, nb, lt);
        @(negedge clk);
    endtask

    initial begin
        int nb, lt, i;
        logic [7:0] qfrz;

        vecs[0]  = '{8'h00, 3'd1, 4'd0,  8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 0};
        vecs[1]  = '{8'h90, 3'd6, 4'd3,  8'h00, 1'b0, 1'b0, 8'hF2, 1'b1, 1'b0, 3};
        vecs[2]  = '{8'h81, 3'd5, 4'd4,  8'h00, 1'b0, 1'b0, 8'h18, 1'b1, 1'b0, 4};
        vecs[3]  = '{8'h5A, 3'd0, 4'd5,  8'hFF, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 0};
        vecs[4]  = '{8'h5A, 3'd3, 4'd0,  8'hFF, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 0};
        vecs[5]  = '{8'h01, 3'd4, 4'd1,  8'h00, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1, 1};
        vecs[6]  = '{8'h80, 3'd7, 4'd1,  8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1};
        vecs[7]  = '{8'h00, 3'd3, 4'd9,  8'h00, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 9};
        vecs[8]  = '{8'hFF, 3'd2, 4'd8,  8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8};
        vecs[9]  = '{8'h96, 3'd2, 4'd2,  8'h00, 1'b1, 1'b0, 8'hE5, 1'b1, 1'b1, 2};
        vecs[10] = '{8'h96, 3'd3, 4'd2,  8'h00, 1'b0, 1'b0, 8'h58, 1'b1, 1'b0, 2};
        vecs[11] = '{8'h3D, 3'd5, 4'd8,  8'h00, 1'b0, 1'b0, 8'h3D, 1'b1, 1'b1, 8};
        vecs[12] = '{8'hC3, 3'd6, 4'd12, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 12};

        // Reset state, even with the clock running.
        repeat (2) @(negedge clk);
        check("rst_q", 64'(q), 64'h0);
        check("rst_ser", 64'(ser_out), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        rst = 1'b1;

        foreach (vecs[n]) begin
            load(vecs[n].preset);
            msb_in = vecs[n].msb;
            lsb_in = vecs[n].lsb;
            do_op(vecs[n].op, vecs[n].k, vecs[n].ld, nb, lt);
            check($sformatf("v%0d_q", n), 64'(q), 64'(vecs[n].exp_q));
            if (vecs[n].chk_ser) check($sformatf("v%0d_ser", n), 64'(ser_out), 64'(vecs[n].exp_ser));
            check($sformatf("v%0d_busy", n), 64'(nb), 64'(vecs[n].exp_busy));
            check($sformatf("v%0d_lat", n), 64'(lt), 64'(vecs[n].exp_busy + 1));
            @(negedge clk);
            check($sformatf("v%0d_done_1cyc", n), 64'(done), 64'h0);
        end

        // Enable dropped for two cycles mid-RUN: everything freezes.
        load(8'h00);
        msb_in = 1'b1;
        @(negedge clk);
        start = 1'b1; op = 3'd2; shamt = 4'd5;
        @(negedge clk);
        start = 1'b0; op = 3'd0; shamt = 4'd0;
        nb = 0; i = 0; qfrz = '0;
        while (!done && i < 100) begin
            if (busy) nb++;
            if (i == 2) begin en = 1'b0; qfrz = q; end
            if (i == 3 || i == 4) check("en_frozen_q", 64'(q), 64'(qfrz));
            if (i == 4) en = 1'b1;
            @(negedge clk);
            i++;
        end
        check("en_busy", 64'(nb), 64'd7);
        check("en_q", 64'(q), 64'hF8);
        check("en_ser", 64'(ser_out), 64'h0);
        msb_in = 1'b0;
        @(negedge clk);

        // start during RUN is ignored and not queued; op changes after capture have no effect.
        load(8'h3C);
        @(negedge clk);
        start = 1'b1; op = 3'd4; shamt = 4'd3;
        @(negedge clk);
        start = 1'b0;
        nb = 0; i = 0;
        while (!done && i < 100) begin
            if (busy) nb++;
            if (i == 1) begin start = 1'b1; op = 3'd1; d = 8'hFF; shamt = 4'd9; end
            if (i == 2) start = 1'b0;
            @(negedge clk);
            i++;
        end
        check("ign_busy", 64'(nb), 64'd3);
        check("ign_q", 64'(q), 64'h87);
        repeat (3) @(negedge clk);
        check("ign_noqueue_q", 64'(q), 64'h87);
        check("ign_noqueue_st", 64'({busy, done}), 64'h0);

        // Async reset during a 6-step run.
        load(8'hAA);
        @(negedge clk);
        start = 1'b1; op = 3'd7; shamt = 4'd6;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_q", 64'(q), 64'h0);
        check("arst_busy", 64'(busy), 64'h0);
        check("arst_done", 64'(done), 64'h0);
        check("arst_ser", 64'(ser_out), 64'h0);
        @(negedge clk);
        rst = 1'b1; start = 1'b1; op = 3'd1; d = 8'h5A;
        @(negedge clk);
        start = 1'b0;
        check("post_rst_done", 64'(done), 64'h1);
        check("post_rst_q", 64'(q), 64'h5A);
        @(negedge clk);
        check("post_rst_idle", 64'({busy, done}), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data register width (legal: 2..64).
REQ-002 Parameter SHAMT_W, default $clog2(WIDTH)+1, SHALL set the shift-count width so that a count of WIDTH is representable.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 en  input  1  SHALL be the global enable; when low, all state SHALL hold (FSM, counter, q, ser_out).
REQ-006 start  input  1  SHALL request an operation; it is sampled only in IDLE with en high.
REQ-007 op  input  3  SHALL select the operation: 0 hold, 1 load, 2 shift-right (msb_in fill), 3 shift-left (lsb_in fill), 4 rotate-right, 5 rotate-left, 6 arithmetic shift-right, 7 logical shift-left (zero fill).
REQ-008 d  input  WIDTH  SHALL be the parallel load data.
REQ-009 shamt  input  SHAMT_W  SHALL be the number of single-bit steps for ops 2-7.
REQ-010 msb_in / lsb_in  input  1 each  SHALL be the serial fill bits for ops 2 / 3, sampled live on every step.
REQ-011 q  output  WIDTH  SHALL be the registered data value.
REQ-012 ser_out  output  1  SHALL be the registered bit most recently shifted or rotated out of q.
REQ-013 busy  output  1  SHALL be high exactly while in RUN.
REQ-014 done  output  1  SHALL be high exactly while in DONE.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 On an enabled edge in IDLE with start high, op and shamt SHALL be captured; op/shamt changes afterwards SHALL have no effect.
REQ-017 Op 1: on the accepting edge, q SHALL take d and the FSM SHALL go to DONE.
REQ-018 Op 0, or ops 2-7 with shamt = 0: on the accepting edge, q SHALL be unchanged and the FSM SHALL go to DONE.
REQ-019 Ops 2-7 with shamt = k > 0: the accepting edge SHALL load the counter with k and enter RUN; each enabled edge in RUN SHALL perform one step and decrement the counter; the step that brings the counter to 0 SHALL also move the FSM to DONE.
REQ-020 Single-step semantics: op 2 q <= {msb_in, q[W-1:1]}; op 3 q <= {q[W-2:0], lsb_in}; op 4 rotate by 1 toward LSB; op 5 rotate by 1 toward MSB; op 6 replicate q[W-1]; op 7 fill 0.
REQ-021 On each step, ser_out SHALL take q[0] for ops 2/4/6 and q[W-1] for ops 3/5/7.
REQ-022 Ops 2-7 with k >= WIDTH SHALL still execute exactly k steps (no saturation).
REQ-023 DONE SHALL last exactly one cycle and return to IDLE on the next edge regardless of en.
REQ-024 start outside IDLE SHALL be ignored and not queued.
REQ-025 Latency from the accepting edge to done high SHALL be 1 edge for ops 0/1/shamt = 0, and k+1 enabled edges otherwise.

Reset
REQ-026 While rst is low: q = 0, ser_out = 0, counter = 0, busy = 0, done = 0, FSM = IDLE, taking effect immediately and independently of clk and en, including mid-RUN.
REQ-027 The first edge after rst deasserts SHALL be able to accept start.

Structure
REQ-028 A shared package shift_pkg SHALL hold the op_e enum (the 8 encodings above) and the state_e enum.
REQ-029 A single combinational sub-module shift_step SHALL compute the next q and the out-bit from (q, op, msb_in, lsb_in); shift_sequencer SHALL own all registers and the FSM.

Verification (WIDTH = 8)
REQ-030 Load d = 8'hA5 -> q = 8'hA5 after the accepting edge; done high for 1 cycle; busy never high.
REQ-031 q = 8'h90, op 6, shamt = 3 -> busy for 3 cycles, then q = 8'hF2, ser_out = 0, done for 1 cycle.
REQ-032 q = 8'h81, op 5, shamt = 4 -> q = 8'h18, ser_out = 0.
REQ-033 q = 8'h00, op 2, msb_in = 1, shamt = 5, en low for 2 cycles mid-RUN -> busy for 7 cycles, q = 8'hF8, all state frozen while en is low.
REQ-034 Pulse start with a different op during RUN -> ignored, result unchanged; op 3, shamt = 0 -> done after 1 edge, q unchanged.
REQ-035 Assert rst during RUN of a 6-step op -> q = 0, busy = 0, done = 0 before the next clk edge; after release, a new load succeeds.
